// File: rtl/image_in_loader.sv
// image_in_loader: streams an 8-bit image into data memory, then raises start_io until the processor reports done.
module image_in_loader #(
    parameter int WIDTH     = 24,
    parameter int PIXELS    = 90000,
    parameter int BASE_ADDR = 302
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_req,
    input  logic             px_valid,
    input  logic [7:0]       px_data,
    output logic             px_ready,
    input  logic             proc_done,
    output logic             mem_sel,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    output logic             start_io,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;
    localparam logic [16:0]      LAST = 17'(PIXELS - 1);
    localparam logic [WIDTH-1:0] BASE = WIDTH'(BASE_ADDR);
    state_t           state_q, state_d;
    logic [16:0]      cnt_q, cnt_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
    logic             done_q, done_d;
    logic             xfer;
    assign px_ready = state_q == LOAD;
    assign mem_sel  = state_q == LOAD || state_q == FLUSH;
    assign start_io = state_q == RUN;
    assign busy     = state_q != IDLE;
    assign xfer     = px_ready && px_valid;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign done     = done_q;
    // Writes are registered: a transfer this cycle appears on the memory port next cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = xfer ? cnt_q + 17'd1 : cnt_q;
        mem_we_d   = xfer;
        mem_addr_d = xfer ? BASE + WIDTH'(cnt_q) : mem_addr_q;
        mem_wd_d   = xfer ? WIDTH'(px_data) : mem_wd_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE:  state_d = load_req ? LOAD : IDLE;
            LOAD:  state_d = (xfer && cnt_q == LAST) ? FLUSH : LOAD;
            FLUSH: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                state_d = proc_done ? IDLE : RUN;
                done_d  = proc_done;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_image_in_loader.sv
// tb_image_in_loader: directed checks of a 4-pixel loader through load, stall, handback and reset cases.
module tb_image_in_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0, px_valid = 1'b0, proc_done = 1'b0;
    logic [7:0]  px_data = 8'h00;
    logic        px_ready, mem_sel, mem_we, start_io, busy, done;
    logic [23:0] mem_addr, mem_wd;
    int          n_tests = 0, n_fail = 0;
    logic [6:0]  pat = 7'b1011001;
    int          k;

    image_in_loader #(.WIDTH(24), .PIXELS(4), .BASE_ADDR(302)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .px_valid(px_valid),
        .px_data(px_data), .px_ready(px_ready), .proc_done(proc_done),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .start_io(start_io), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {px_ready, mem_sel, mem_we, start_io, busy, done}
    function automatic logic [31:0] flags();
        return {26'd0, px_ready, mem_sel, mem_we, start_io, busy, done};
    endfunction

    initial begin
        step();
        chk("reset_flags", flags(), 32'h00);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wd", mem_wd, 0);
        rst_n = 1'b1;
        step();
        chk("idle_flags", flags(), 32'h00);
        load_req = 1'b1; px_valid = 1'b1; px_data = 8'h99;
        step();
        chk("enter_load_flags", flags(), 32'b110010);
        load_req = 1'b0;
        px_data = 8'h11;
        step();
        chk("p0_flags", flags(), 32'b111010);
        chk("p0_addr", mem_addr, 302);
        chk("p0_wd", mem_wd, 32'h11);
        load_req = 1'b1; proc_done = 1'b1; px_data = 8'h22;
        step();
        chk("p1_addr", mem_addr, 303);
        chk("p1_wd", mem_wd, 32'h22);
        load_req = 1'b0; proc_done = 1'b0; px_data = 8'h33;
        step();
        chk("p2_addr", mem_addr, 304);
        chk("p2_wd", mem_wd, 32'h33);
        px_data = 8'h44;
        step();
        chk("flush_flags", flags(), 32'b011010);
        chk("p3_addr", mem_addr, 305);
        chk("p3_wd", mem_wd, 32'h44);
        px_valid = 1'b0;
        step();
        chk("run_flags", flags(), 32'b000110);
        chk("run_addr_hold", mem_addr, 305);
        load_req = 1'b1;
        step();
        chk("run_ignore_load", flags(), 32'b000110);
        load_req = 1'b0; proc_done = 1'b1;
        step();
        chk("handback_flags", flags(), 32'b000001);
        step();
        chk("done_one_cycle", flags(), 32'b000000);
        proc_done = 1'b0; px_valid = 1'b1; px_data = 8'h55;
        step();
        chk("idle_no_accept", flags(), 32'b000000);
        px_valid = 1'b0; load_req = 1'b1;
        step();
        load_req = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            px_valid = pat[i];
            px_data = 8'hA0 + 8'(i);
            step();
            chk($sformatf("stall%0d_we", i), mem_we, pat[i]);
            if (pat[i]) begin
                chk($sformatf("stall%0d_addr", i), mem_addr, 302 + k);
                chk($sformatf("stall%0d_wd", i), mem_wd, 32'hA0 + i);
                k++;
            end
        end
        chk("stall_writes", k, 4);
        chk("stall_flush_flags", flags(), 32'b011010);
        px_valid = 1'b0;
        step();
        chk("stall_run_flags", flags(), 32'b000110);
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
        chk("stall_done", flags(), 32'b000001);
        load_req = 1'b1;
        step();
        load_req = 1'b0; px_valid = 1'b1; px_data = 8'h01;
        step();
        chk("reload_addr", mem_addr, 302);
        px_data = 8'h02;
        step();
        chk("reload2_addr", mem_addr, 303);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_flags", flags(), 32'h00);
        chk("async_reset_addr", mem_addr, 0);
        chk("async_reset_wd", mem_wd, 0);
        px_valid = 1'b0;
        step();
        rst_n = 1'b1;
        load_req = 1'b1;
        step();
        load_req = 1'b0; px_valid = 1'b1; px_data = 8'h7E;
        step();
        chk("after_reset_addr", mem_addr, 302);
        chk("after_reset_wd", mem_wd, 32'h7E);
        chk("after_reset_flags", flags(), 32'b111010);
        px_valid = 1'b0;
        step();
        chk("after_reset_gap", flags(), 32'b110010);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
